y_buf_classifier: RTL

Y_BUF_CLASSIFIER -- requirements
Module: y_buf_classifier

---
 rtl/y_buf_classifier.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/y_buf_classifier.sv
`default_nettype none
// ============================================================================
// Module  : y_buf_classifier
// Brief   : Snoops output-buffer score writes, tracks argmax per image and
//           queues {image, class, score} results in a small FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module y_buf_classifier #(
    parameter int IN_IMG_NUM       = 10,
    parameter int NUM_CLASS        = 10,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        y_buf_en,
    input  logic                        y_buf_wr_en,
    input  logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr,
    input  logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data,
    output logic                        pred_valid_o,
    input  logic                        pred_ready_i,
    output logic [3:0]                  pred_class_o,
    output logic [7:0]                  pred_img_o,
    output logic [Y_BUF_DATA_WIDTH-1:0] pred_score_o,
    output logic                        addr_err_o,
    output logic                        overflow_o,
    output logic                        all_done_o
);

    localparam int c_CLS_W   = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;
    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = 8 + 4 + Y_BUF_DATA_WIDTH;

    localparam logic [c_CLS_W-1:0] c_CLS_LAST = c_CLS_W'(NUM_CLASS - 1);
    localparam logic [7:0]         c_IMG_LAST = 8'(IN_IMG_NUM - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ACCUM = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]                         r_state;
    logic [1:0]                         w_state_nxt;
    logic [Y_BUF_ADDR_WIDTH-1:0]        r_exp_addr;
    logic [c_CLS_W-1:0]                 r_cls;
    logic [7:0]                         r_img;
    logic signed [Y_BUF_DATA_WIDTH-1:0] r_max;
    logic [3:0]                         r_max_cls;
    logic                               r_addr_err;
    logic                               r_overflow;

    logic                               w_wr;
    logic                               w_ok;
    logic                               w_last_cls;
    logic                               w_last_img;
    logic signed [Y_BUF_DATA_WIDTH-1:0] w_win_score;
    logic [3:0]                         w_win_cls;

    logic [c_ENTRY_W-1:0]               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]                 r_wr_ptr;
    logic [c_PTR_W-1:0]                 r_rd_ptr;
    logic [c_CNT_W-1:0]                 r_count;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_full;
    logic                               w_push_ok;
    logic [c_ENTRY_W-1:0]               w_head;

    // Alignment is checked explicitly so a misaligned write never matches.
    assign w_wr       = y_buf_en & y_buf_wr_en;
    assign w_ok       = w_wr && (r_state != c_S_DONE) && (y_buf_addr[1:0] == 2'b00)
                        && (y_buf_addr == r_exp_addr);
    assign w_last_cls = (r_cls == c_CLS_LAST);
    assign w_last_img = (r_img == c_IMG_LAST);

    // Winner including the word being written; strict compare keeps the lower index on ties.
    always_comb begin
        w_win_score = r_max;
        w_win_cls   = r_max_cls;
        if ((r_cls == '0) || ($signed(y_buf_data) > r_max)) begin
            w_win_score = $signed(y_buf_data);
            w_win_cls   = 4'(r_cls);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_ACCUM: begin
                if (w_ok) begin
                    if (w_last_cls) w_state_nxt = w_last_img ? c_S_DONE : c_S_IDLE;
                    else            w_state_nxt = c_S_ACCUM;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_S_IDLE;
            r_exp_addr <= '0;
            r_cls      <= '0;
            r_img      <= '0;
            r_max      <= '0;
            r_max_cls  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr && !w_ok) r_addr_err <= 1'b1;
            if (w_ok) begin
                r_exp_addr <= r_exp_addr + Y_BUF_ADDR_WIDTH'(4);
                r_max      <= w_win_score;
                r_max_cls  <= w_win_cls;
                if (w_last_cls) begin
                    r_cls <= '0;
                    r_img <= r_img + 8'd1;
                end else begin
                    r_cls <= r_cls + c_CLS_W'(1);
                end
            end
        end
    end

    // Result FIFO: a full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = w_ok && w_last_cls;
    assign w_pop     = (r_count != '0) && pred_ready_i;
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {r_img, w_win_cls, w_win_score};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            if (w_push_ok) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign pred_valid_o = (r_count != '0);
    assign pred_img_o   = pred_valid_o ? w_head[c_ENTRY_W-1 -: 8] : 8'd0;
    assign pred_class_o = pred_valid_o ? w_head[Y_BUF_DATA_WIDTH+3 : Y_BUF_DATA_WIDTH] : 4'd0;
    assign pred_score_o = pred_valid_o ? w_head[Y_BUF_DATA_WIDTH-1:0] : '0;
    assign addr_err_o   = r_addr_err;
    assign overflow_o   = r_overflow;
    assign all_done_o   = (r_state == c_S_DONE) && (r_count == '0);

endmodule
`default_nettype wire
